cmd_seq_proc: RTL and testbench

Parametrised command-sequence processor: the next generation of the maze-runner command processor. It assembles multi-byte command packets from the UART receiver and queues them in a packet FIFO. Each line-loss event consumes one 2-bit command and drives the steering error offset `err_opn_lp` to the line-follow PID, with `go` and `buzz` outputs. It sits between `UART_rx` and the PID/motor path, and adds packet queueing, configurable packet length, configurable offsets and bumper-abort handling.

---
 rtl/cmd_seq_pkg.sv | 31 +++
 rtl/pkt_fifo.sv | 42 ++++
 rtl/cmd_seq_proc.sv | 216 +++++++++++++++++++++
 tb/tb_cmd_seq_proc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types and default constants for the command-sequence processor.
package cmd_seq_pkg;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    VR   = 2'b01,
    VL   = 2'b10,
    TA   = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FOLLOW,
    S_DECODE,
    S_VEER,
    S_TURN1,
    S_TURN2,
    S_BUMP
  } state_t;

  localparam logic [15:0] DEF_VEER_OFF  = 16'h0340;
  localparam logic [15:0] DEF_TURN1_OFF = 16'h01E0;
  localparam logic [15:0] DEF_TURN2_OFF = 16'h0380;
  localparam logic [21:0] DEF_TURN_CYC  = 22'd1_350_000;

  function automatic logic signed [15:0] neg16(input logic [15:0] mag);
    return -$signed(mag);
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Packet FIFO with full/empty flags; a pop on a full FIFO makes room for a
// push in the same cycle.
module pkt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cmd_seq_proc.sv
// Command-sequence processor: assembles UART bytes into command packets,
// queues them, and consumes one 2-bit command per line-loss event.
module cmd_seq_proc
  import cmd_seq_pkg::*;
#(
  parameter int          FAST_SIM   = 0,
  parameter int          CMD_BYTES  = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] VEER_OFF   = DEF_VEER_OFF,
  parameter logic [15:0] TURN1_OFF  = DEF_TURN1_OFF,
  parameter logic [15:0] TURN2_OFF  = DEF_TURN2_OFF,
  parameter logic [21:0] TURN1_CYC  = DEF_TURN_CYC,
  parameter logic [21:0] TURN2_CYC  = DEF_TURN_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_rdy,
  output logic               clr_rx_rdy,
  input  logic               line_present,
  input  logic               BMPL_n,
  input  logic               BMPR_n,
  output logic               go,
  output logic signed [15:0] err_opn_lp,
  output logic               buzz,
  output logic               fifo_full,
  output logic               ovf
);
  localparam int          PKT_W     = 8 * CMD_BYTES;
  localparam int          NCMD      = 4 * CMD_BYTES;
  localparam int          IDX_W     = $clog2(NCMD + 1);
  localparam logic [1:0]  BCNT_LAST = 2'(CMD_BYTES - 1);
  localparam logic [21:0] T1_LEN    = (FAST_SIM != 0) ? (TURN1_CYC >> 10) : TURN1_CYC;
  localparam logic [21:0] T2_LEN    = (FAST_SIM != 0) ? (TURN2_CYC >> 10) : TURN2_CYC;
  localparam logic [21:0] T1_LD     = (T1_LEN == 22'd0) ? 22'd0 : T1_LEN - 22'd1;
  localparam logic [21:0] T2_LD     = (T2_LEN == 22'd0) ? 22'd0 : T2_LEN - 22'd1;

  state_t             r_state, w_nxt_state;
  logic               r_go, w_nxt_go;
  logic signed [15:0] r_err, w_nxt_err;
  logic               r_buzz, w_nxt_buzz;
  logic [21:0]        r_tmr, w_nxt_tmr;
  logic [IDX_W-1:0]   r_idx, w_nxt_idx;
  logic               r_lvr, w_nxt_lvr;
  logic               r_line_d, r_clr, r_ovf;
  logic [1:0]         r_bcnt;
  logic [PKT_W-1:0]   r_shift, r_pkt;
  logic [PKT_W-1:0]   w_pkt_in, w_fifo_q;
  logic               w_accept, w_push, w_pop, w_full, w_empty, w_bump;
  cmd_t               w_cmd;

  // rx_rdy stays high through the acknowledge cycle, so that cycle is skipped.
  assign w_accept = rx_rdy & ~r_clr;
  assign w_push   = w_accept && (r_bcnt == BCNT_LAST);
  assign w_pkt_in = (r_shift << 8) | PKT_W'(rx_data);
  assign w_bump   = ~BMPL_n | ~BMPR_n;
  assign w_cmd    = cmd_t'(2'(r_pkt >> {r_idx, 1'b0}));

  pkt_fifo #(
    .WIDTH(PKT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_pkt_in),
    .i_pop  (w_pop),
    .o_data (w_fifo_q),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_go    = r_go;
    w_nxt_err   = r_err;
    w_nxt_buzz  = r_buzz;
    w_nxt_tmr   = r_tmr;
    w_nxt_idx   = r_idx;
    w_nxt_lvr   = r_lvr;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_nxt_go   = 1'b0;
        w_nxt_err  = '0;
        w_nxt_buzz = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_idx   = '0;
          w_nxt_state = S_ARM;
        end
      end
      S_ARM: begin
        w_nxt_go   = 1'b0;
        w_nxt_err  = '0;
        w_nxt_buzz = 1'b0;
        if (line_present) begin
          w_nxt_go    = 1'b1;
          w_nxt_state = S_FOLLOW;
        end
      end
      S_FOLLOW: begin
        if (w_bump) w_nxt_state = S_BUMP;
        else if (!line_present && r_line_d) w_nxt_state = S_DECODE;
      end
      S_DECODE: begin
        if (r_idx == IDX_W'(NCMD)) begin
          w_nxt_go    = 1'b0;
          w_nxt_err   = '0;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_idx = r_idx + IDX_W'(1);
          unique case (w_cmd)
            VR: begin
              w_nxt_err   = neg16(VEER_OFF);
              w_nxt_lvr   = 1'b1;
              w_nxt_state = S_VEER;
            end
            VL: begin
              w_nxt_err   = $signed(VEER_OFF);
              w_nxt_lvr   = 1'b0;
              w_nxt_state = S_VEER;
            end
            TA: begin
              w_nxt_err   = r_lvr ? $signed(TURN1_OFF) : neg16(TURN1_OFF);
              w_nxt_tmr   = T1_LD;
              w_nxt_state = S_TURN1;
            end
            default: begin
              w_nxt_go    = 1'b0;
              w_nxt_err   = '0;
              w_nxt_state = S_IDLE;
            end
          endcase
        end
      end
      S_VEER: begin
        if (w_bump) w_nxt_state = S_BUMP;
        else if (line_present) begin
          w_nxt_err   = '0;
          w_nxt_state = S_FOLLOW;
        end
      end
      S_TURN1: begin
        if (w_bump) w_nxt_state = S_BUMP;
        else if (r_tmr == 22'd0) begin
          w_nxt_err   = r_lvr ? neg16(TURN2_OFF) : $signed(TURN2_OFF);
          w_nxt_tmr   = T2_LD;
          w_nxt_state = S_TURN2;
        end else w_nxt_tmr = r_tmr - 22'd1;
      end
      S_TURN2: begin
        if (w_bump) w_nxt_state = S_BUMP;
        else if (r_tmr == 22'd0) begin
          w_nxt_go    = 1'b0;
          w_nxt_err   = '0;
          w_nxt_state = S_ARM;
        end else w_nxt_tmr = r_tmr - 22'd1;
      end
      S_BUMP: begin
        if (!w_bump) begin
          w_nxt_buzz  = 1'b0;
          w_nxt_state = S_ARM;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // Bump entry overrides whatever the active state decided this cycle.
    if (w_nxt_state == S_BUMP) begin
      w_nxt_go   = 1'b0;
      w_nxt_err  = '0;
      w_nxt_buzz = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_go     <= 1'b0;
      r_err    <= '0;
      r_buzz   <= 1'b0;
      r_tmr    <= '0;
      r_idx    <= '0;
      r_lvr    <= 1'b0;
      r_line_d <= 1'b0;
      r_clr    <= 1'b0;
      r_ovf    <= 1'b0;
      r_bcnt   <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_go     <= w_nxt_go;
      r_err    <= w_nxt_err;
      r_buzz   <= w_nxt_buzz;
      r_tmr    <= w_nxt_tmr;
      r_idx    <= w_nxt_idx;
      r_lvr    <= w_nxt_lvr;
      r_line_d <= line_present;
      r_clr    <= w_accept;
      if (w_accept) r_bcnt <= w_push ? 2'd0 : r_bcnt + 2'd1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_shift <= w_pkt_in;
    if (w_pop)    r_pkt   <= w_fifo_q;
  end

  assign clr_rx_rdy = r_clr;
  assign go         = r_go;
  assign err_opn_lp = r_err;
  assign buzz       = r_buzz;
  assign fifo_full  = w_full;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cmd_seq_proc.sv
// Directed bench for cmd_seq_proc: a 2-byte-packet instance and a 1-byte-packet
// instance share stimulus; sel chooses which one is observed.
module tb_cmd_seq_proc;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_data;
  logic rx_rdy, line_present, BMPL_n, BMPR_n;

  logic clr1, go1, buzz1, full1, ovf1;
  logic signed [15:0] err1;
  logic clr2, go2, buzz2, full2, ovf2;
  logic signed [15:0] err2;

  logic sel;
  logic go_o, buzz_o, clr_o, full_o, ovf_o;
  logic [15:0] err_o;
  assign go_o   = sel ? go2   : go1;
  assign buzz_o = sel ? buzz2 : buzz1;
  assign clr_o  = sel ? clr2  : clr1;
  assign full_o = sel ? full2 : full1;
  assign ovf_o  = sel ? ovf2  : ovf1;
  assign err_o  = sel ? err2  : err1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmd_seq_proc #(
    .FAST_SIM(1), .CMD_BYTES(2), .FIFO_DEPTH(4),
    .TURN1_CYC(22'd10240), .TURN2_CYC(22'd15360)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr1),
    .line_present(line_present), .BMPL_n(BMPL_n), .BMPR_n(BMPR_n),
    .go(go1), .err_opn_lp(err1), .buzz(buzz1), .fifo_full(full1), .ovf(ovf1)
  );

  cmd_seq_proc #(
    .FAST_SIM(1), .CMD_BYTES(1), .FIFO_DEPTH(4),
    .TURN1_CYC(22'd10240), .TURN2_CYC(22'd15360)
  ) dut1b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr2),
    .line_present(line_present), .BMPL_n(BMPL_n), .BMPR_n(BMPR_n),
    .go(go2), .err_opn_lp(err2), .buzz(buzz2), .fifo_full(full2), .ovf(ovf2)
  );

  typedef struct {
    logic        line;
    int          ticks;
    logic        exp_go;
    logic [15:0] exp_err;
    logic        exp_buzz;
    string       nm;
  } vec_t;
  vec_t vecs[12];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(1);
    chk("clr_ack", clr_o, 1);
    rx_rdy = 1'b0;
    tick(1);
    chk("clr_drop", clr_o, 0);
  endtask

  task automatic do_reset();
    rx_rdy = 1'b0; rx_data = 8'h00; line_present = 1'b0;
    BMPL_n = 1'b1; BMPR_n = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic lose(input logic [15:0] e, input string nm);
    line_present = 1'b0;
    tick(2);
    chk(nm, err_o, e);
  endtask

  task automatic regain(input string nm);
    line_present = 1'b1;
    tick(1);
    chk(nm, err_o, 0);
  endtask

  task automatic start_follow(input string nm);
    line_present = 1'b1;
    tick(2);
    chk(nm, go_o, 1);
  endtask

  task automatic stop_check(input string nm);
    line_present = 1'b0;
    tick(2);
    chk(nm, go_o, 0);
  endtask

  task automatic exec1(input logic [15:0] e, input string nm);
    start_follow({nm, "_go"});
    lose(e, {nm, "_err"});
    regain({nm, "_back"});
    stop_check({nm, "_stop"});
  endtask

  task automatic wait_turn_end(input string nm);
    int k = 0;
    while (err_o != 16'h0000 && k < 60) begin
      tick(1);
      k++;
    end
    chk({nm, "_err0"}, err_o, 0);
    chk({nm, "_go0"}, go_o, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1,  1'b1, 16'h0000, 1'b0, "s1_follow"};
    vecs[1]  = '{1'b0, 2,  1'b1, 16'hFCC0, 1'b0, "s1_veer_r"};
    vecs[2]  = '{1'b1, 1,  1'b1, 16'h0000, 1'b0, "s1_veer_r_end"};
    vecs[3]  = '{1'b0, 2,  1'b1, 16'h0340, 1'b0, "s1_veer_l"};
    vecs[4]  = '{1'b1, 1,  1'b1, 16'h0000, 1'b0, "s1_veer_l_end"};
    vecs[5]  = '{1'b0, 2,  1'b1, 16'hFE20, 1'b0, "s1_turn1"};
    vecs[6]  = '{1'b0, 8,  1'b1, 16'hFE20, 1'b0, "s1_turn1_hold"};
    vecs[7]  = '{1'b0, 3,  1'b1, 16'h0380, 1'b0, "s1_turn2"};
    vecs[8]  = '{1'b0, 16, 1'b0, 16'h0000, 1'b0, "s1_turn_done"};
    vecs[9]  = '{1'b1, 1,  1'b1, 16'h0000, 1'b0, "s1_follow2"};
    vecs[10] = '{1'b0, 2,  1'b0, 16'h0000, 1'b0, "s1_stop"};
    vecs[11] = '{1'b1, 3,  1'b0, 16'h0000, 1'b0, "s1_idle"};

    sel = 1'b0;
    do_reset();
    chk("rst_go", go_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_buzz", buzz_o, 0);
    chk("rst_clr", clr_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_full", full_o, 0);

    // Basic packet: VR, VL, TA, STOP
    send_byte(8'h00);
    send_byte(8'h39);
    for (int i = 0; i < 12; i++) begin
      line_present = vecs[i].line;
      tick(vecs[i].ticks);
      chk({vecs[i].nm, ".go"}, go_o, vecs[i].exp_go);
      chk({vecs[i].nm, ".err"}, err_o, vecs[i].exp_err);
      chk({vecs[i].nm, ".buzz"}, buzz_o, vecs[i].exp_buzz);
    end

    // FIFO fill and overflow: one packet goes active, four queue, sixth drops
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h06);
    chk("fifo_full_4", full_o, 1);
    chk("no_ovf_yet", ovf_o, 0);
    send_byte(8'h00); send_byte(8'h01);
    chk("ovf_set", ovf_o, 1);
    chk("fifo_still_full", full_o, 1);
    exec1(16'hFCC0, "p1");
    exec1(16'h0340, "p2");
    chk("fifo_not_full", full_o, 0);
    exec1(16'hFCC0, "p3");
    exec1(16'h0340, "p4");
    start_follow("p5_go");
    lose(16'h0340, "p5_vl");
    regain("p5_back1");
    lose(16'hFCC0, "p5_vr");
    regain("p5_back2");
    stop_check("p5_stop");
    line_present = 1'b1;
    tick(3);
    chk("dropped_pkt_idle", go_o, 0);
    chk("ovf_sticky", ovf_o, 1);

    // Bump during TURN1, then resume with the following command
    do_reset();
    send_byte(8'h00);
    send_byte(8'h07);
    start_follow("b_go");
    lose(16'hFE20, "b_turn1");
    tick(2);
    BMPL_n = 1'b0;
    tick(1);
    chk("bump_go", go_o, 0);
    chk("bump_err", err_o, 0);
    chk("bump_buzz", buzz_o, 1);
    tick(2);
    chk("bump_hold_buzz", buzz_o, 1);
    BMPL_n = 1'b1;
    tick(1);
    chk("bump_release_buzz", buzz_o, 0);
    line_present = 1'b1;
    tick(1);
    chk("bump_rearm_go", go_o, 1);
    lose(16'hFCC0, "bump_next_cmd");

    // Stop first, second packet already queued
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h02);
    start_follow("q_go");
    stop_check("q_stop");
    chk("q_stop_err", err_o, 0);
    start_follow("q_second_go");
    lose(16'h0340, "q_second_vl");

    // Reset mid-VEER with a byte half-assembled
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    start_follow("r_go");
    lose(16'hFCC0, "r_veer");
    rx_data = 8'hAA;
    rx_rdy  = 1'b1;
    tick(1);
    chk("r_clr_before", clr_o, 1);
    rst    = 1'b1;
    rx_rdy = 1'b0;
    #1;
    chk("r_async_go", go_o, 0);
    chk("r_async_err", err_o, 0);
    chk("r_async_clr", clr_o, 0);
    chk("r_async_buzz", buzz_o, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    send_byte(8'h00); send_byte(8'h02);
    start_follow("r_fresh_go");
    lose(16'h0340, "r_fresh_vl");

    // One-byte packets: 8'hFF is four turn-arounds, then exhaustion
    sel = 1'b1;
    do_reset();
    send_byte(8'hFF);
    for (int t = 0; t < 4; t++) begin
      start_follow($sformatf("ta%0d_go", t));
      lose(16'hFE20, $sformatf("ta%0d_turn1", t));
      wait_turn_end($sformatf("ta%0d", t));
    end
    start_follow("ta_exh_go");
    stop_check("ta_exhausted");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
